// File: rtl/harvard_bus_pkg.sv
// Shared types and constants for the CPU data-port to handshaked-memory bridge.
package harvard_bus_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DONE} bridge_state_t;
  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/harvard_data_bridge_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)                       count_d = '0;
    else if (inc && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/harvard_data_bridge.sv
// Freezes the CPU (clk_enable=0) while a data access runs on a variable-latency
// req/ack memory; bounded wait with sticky error flags and a stall counter.
module harvard_data_bridge
  import harvard_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = DEFAULT_ERR_RDATA
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_active,
  input  logic [31:0] cpu_data_address,
  input  logic        cpu_data_read,
  input  logic        cpu_data_write,
  input  logic [31:0] cpu_data_writedata,
  output logic [31:0] cpu_data_readdata,
  output logic        cpu_clk_enable,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        bus_error,
  output logic        protocol_error,
  output logic [31:0] stall_count
);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  bridge_state_t state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic        bus_err_q, bus_err_d;
  logic        prot_err_q, prot_err_d;
  logic        clk_en;
  logic        pending, expire;
  logic [15:0] tcnt;

  assign pending = cpu_active & (cpu_data_read | cpu_data_write);
  // tcnt counts completed REQ cycles, so expiry fires on the TIMEOUT_CYCLES-th one
  assign expire  = (state_q == REQ) && (tcnt == TO_LAST);

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rbuf_d      = rbuf_q;
    bus_err_d   = bus_err_q;
    prot_err_d  = prot_err_q;
    clk_en      = 1'b1;
    case (state_q)
      IDLE: begin
        clk_en = !pending;
        if (pending) begin
          mem_req_d   = 1'b1;
          mem_we_d    = cpu_data_write;
          mem_addr_d  = cpu_data_address;
          mem_wdata_d = cpu_data_writedata;
          state_d     = REQ;
          if (cpu_data_read && cpu_data_write) prot_err_d = 1'b1;
        end
      end
      REQ: begin
        clk_en = 1'b0;
        // ack on the expiry cycle still counts as success
        if (mem_ack) begin
          if (!mem_we_q) rbuf_d = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = DONE;
        end else if (expire) begin
          if (!mem_we_q) rbuf_d = ERR_RDATA;
          bus_err_d = 1'b1;
          mem_req_d = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        clk_en  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rbuf_q      <= '0;
      bus_err_q   <= 1'b0;
      prot_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rbuf_q      <= rbuf_d;
      bus_err_q   <= bus_err_d;
      prot_err_q  <= prot_err_d;
    end
  end

  sat_counter #(.W(16)) u_timeout (
    .clk(clk), .reset_n(reset_n),
    .clr(state_q != REQ), .inc(state_q == REQ),
    .count(tcnt)
  );

  sat_counter #(.W(32)) u_stall (
    .clk(clk), .reset_n(reset_n),
    .clr(1'b0), .inc(!clk_en),
    .count(stall_count)
  );

  assign cpu_clk_enable    = clk_en;
  assign cpu_data_readdata = rbuf_q;
  assign mem_req           = mem_req_q;
  assign mem_we            = mem_we_q;
  assign mem_addr          = mem_addr_q;
  assign mem_wdata         = mem_wdata_q;
  assign bus_error         = bus_err_q;
  assign protocol_error    = prot_err_q;
endmodule

// File: tb/tb_harvard_data_bridge.sv
// Bench for harvard_data_bridge: directed vector table, reset corner case and
// random accesses against a transaction-level model.
module tb_harvard_data_bridge;
  localparam int T = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_active = 1'b0;
  logic [31:0] cpu_data_address = '0;
  logic        cpu_data_read = 1'b0;
  logic        cpu_data_write = 1'b0;
  logic [31:0] cpu_data_writedata = '0;
  logic [31:0] cpu_data_readdata;
  logic        cpu_clk_enable;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        bus_error, protocol_error;
  logic [31:0] stall_count;

  int total = 0;
  int bad = 0;
  int exp_total_stall = 0;

  harvard_data_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_active(cpu_active),
    .cpu_data_address(cpu_data_address), .cpu_data_read(cpu_data_read),
    .cpu_data_write(cpu_data_write), .cpu_data_writedata(cpu_data_writedata),
    .cpu_data_readdata(cpu_data_readdata), .cpu_clk_enable(cpu_clk_enable),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_error(bus_error),
    .protocol_error(protocol_error), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
    int          exp_stall;
    logic [31:0] exp_rdata;
    logic        exp_be;
    logic        exp_pe;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One CPU access; the memory side acks `d` cycles after REQ entry.
  task automatic access(input logic [31:0] addr, input logic rd, input logic wr,
                        input logic [31:0] wdata, input int d, input logic [31:0] rdat,
                        input int exp_stall, input logic [31:0] exp_rdata,
                        input logic exp_be, input logic exp_pe);
    int stalls = 0;
    int reqc = 0;
    int cyc = 0;
    bit done = 0;
    bit stable = 1;
    logic [31:0] a0 = '0, w0 = '0;
    logic we0 = 1'b0;
    exp_total_stall += exp_stall;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cpu_active = 1'b1;
      cpu_data_address = addr;
      cpu_data_read = rd;
      cpu_data_write = wr;
      cpu_data_writedata = wdata;
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (mem_req) begin
        if (reqc == 0) begin
          a0 = mem_addr; w0 = mem_wdata; we0 = mem_we;
        end else if (mem_addr !== a0 || mem_wdata !== w0 || mem_we !== we0) begin
          stable = 0;
        end
        if (reqc == d) begin
          mem_ack = 1'b1;
          mem_rdata = rdat;
        end
        reqc++;
      end
      #1;
      if (!cpu_clk_enable) stalls++;
      else if (stalls > 0) begin
        done = 1;
        chk("done_readdata", cpu_data_readdata, exp_rdata);
        chk("stall_count", stall_count, exp_total_stall);
      end
      cyc++;
    end
    chk("done_reached", 32'(done), 32'd1);
    chk("stall_cycles", stalls, exp_stall);
    chk("req_cycles", reqc, (d < T) ? d + 1 : T);
    chk("req_stable", 32'(stable), 32'd1);
    chk("mem_addr", a0, addr);
    chk("mem_wdata", w0, wdata);
    chk("mem_we", 32'(we0), 32'(wr));
    chk("bus_error", 32'(bus_error), 32'(exp_be));
    chk("protocol_error", 32'(protocol_error), 32'(exp_pe));
  endtask

  task automatic idle_cycle(input logic active, input logic rd, input logic wr, input logic ack);
    @(negedge clk);
    cpu_active = active;
    cpu_data_read = rd;
    cpu_data_write = wr;
    mem_ack = ack;
    mem_rdata = $urandom;
    #1;
    chk("idle_clk_en", 32'(cpu_clk_enable), 32'd1);
    chk("idle_mem_req", 32'(mem_req), 32'd0);
  endtask

  initial begin
    logic [31:0] m_rbuf;
    logic m_be, m_pe;

    tbl[0] = '{32'h0000_1004, 1'b1, 1'b0, 32'h0,          3,   32'h1234_5678, 5, 32'h1234_5678, 1'b0, 1'b0};
    tbl[1] = '{32'h0000_0020, 1'b0, 1'b1, 32'hCAFE_F00D, 0,   32'h0,         2, 32'h1234_5678, 1'b0, 1'b0};
    tbl[2] = '{32'h0000_0040, 1'b1, 1'b0, 32'h0,          1,   32'hA5A5_0001, 3, 32'hA5A5_0001, 1'b0, 1'b0};
    tbl[3] = '{32'h0000_0044, 1'b1, 1'b0, 32'h0,          3,   32'h0BAD_F00D, 5, 32'h0BAD_F00D, 1'b0, 1'b0};
    tbl[4] = '{32'h0000_0048, 1'b1, 1'b0, 32'h0,          100, 32'h0,         5, 32'hDEAD_BEEF, 1'b1, 1'b0};
    tbl[5] = '{32'h0000_004C, 1'b1, 1'b1, 32'h1111_2222, 2,   32'h5555_5555, 4, 32'hDEAD_BEEF, 1'b1, 1'b1};
    tbl[6] = '{32'h0000_0050, 1'b1, 1'b0, 32'h0,          0,   32'h0000_0077, 2, 32'h0000_0077, 1'b1, 1'b1};

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_clk_en", 32'(cpu_clk_enable), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_readdata", cpu_data_readdata, 32'd0);
    chk("rst_bus_error", 32'(bus_error), 32'd0);
    chk("rst_prot_error", 32'(protocol_error), 32'd0);
    chk("rst_stall_count", stall_count, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // idle pass-through
    for (int i = 0; i < 10; i++) idle_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("idle_stall_count", stall_count, 32'd0);

    for (int i = 0; i < 7; i++) begin
      access(tbl[i].addr, tbl[i].rd, tbl[i].wr, tbl[i].wdata, tbl[i].delay, tbl[i].rdata,
             tbl[i].exp_stall, tbl[i].exp_rdata, tbl[i].exp_be, tbl[i].exp_pe);
      idle_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    end

    // inactive CPU strobes are ignored, stray acks too
    for (int i = 0; i < 4; i++) idle_cycle(1'b0, 1'b1, 1'b1, 1'(i));
    chk("inactive_stall_count", stall_count, 32'(exp_total_stall));

    // reset asserted in the 2nd REQ cycle
    @(negedge clk);
    cpu_active = 1'b1; cpu_data_read = 1'b1; cpu_data_write = 1'b0;
    cpu_data_address = 32'h80; mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    cpu_data_read = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    mem_ack = 1'b1;
    #1;
    chk("stray_ack_clk_en", 32'(cpu_clk_enable), 32'd1);
    chk("stray_ack_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("post_rst_clk_en", 32'(cpu_clk_enable), 32'd1);
    chk("post_rst_req", 32'(mem_req), 32'd0);
    chk("post_rst_stall", stall_count, 32'd0);
    chk("post_rst_be", 32'(bus_error), 32'd0);
    chk("post_rst_pe", 32'(protocol_error), 32'd0);

    // random accesses against the transaction model
    exp_total_stall = 0;
    m_rbuf = '0; m_be = 1'b0; m_pe = 1'b0;
    for (int n = 0; n < 40; n++) begin
      int r, d;
      logic rd, wr, ok;
      logic [31:0] rdat;
      r = $urandom_range(0, 9);
      rd = (r <= 5);
      wr = (r == 0) || (r > 5);
      d = $urandom_range(0, 5);
      rdat = $urandom;
      ok = (d < T);
      if (rd && !wr) m_rbuf = ok ? rdat : ERR;
      m_be = m_be | !ok;
      m_pe = m_pe | (rd & wr);
      access($urandom, rd, wr, $urandom, d, rdat, ok ? 2 + d : 1 + T, m_rbuf, m_be, m_pe);
      for (int k = $urandom_range(0, 2); k > 0; k--)
        idle_cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
